// File: rtl/data_memory_sync_if.sv
// ----------------------------------------------------------------------------
// data_memory_sync_if
// Request/response bundle between the MEM stage and the data memory.
//   MemRead   : read request, sampled at the rising edge
//   MemWrite  : write request, sampled at the rising edge
//   ALUResult : word address shared by read and write
//   WriteData : store data
//   ReadData  : registered read data (holds until the next accepted read)
//   ReadValid : one-cycle strobe, ReadData updated by the previous edge's read
//   Busy      : clear sequence running, requests are ignored
// Modports: master = pipeline side, slave = memory side.
// ----------------------------------------------------------------------------
interface data_memory_sync_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] ALUResult;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              ReadValid;
    logic              Busy;

    modport master (
        output MemRead, MemWrite, ALUResult, WriteData,
        input  ReadData, ReadValid, Busy
    );

    modport slave (
        input  MemRead, MemWrite, ALUResult, WriteData,
        output ReadData, ReadValid, Busy
    );
endinterface

// File: rtl/data_memory_sync.sv
// ----------------------------------------------------------------------------
// data_memory_sync
// Parametrised synchronous-read data memory for the MEM stage. After reset a
// two-state FSM writes CLEAR_VAL into one word per cycle; Busy stays high
// until the last word is written and requests are ignored meanwhile.
// Ports:
//   CLK   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : data_memory_sync_if.slave (request inputs, ReadData/ReadValid/Busy)
// RDW_MODE selects same-address read-during-write: 0 = old data, 1 = new data.
// ----------------------------------------------------------------------------
module data_memory_sync #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter int                RDW_MODE  = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic               CLK,
    input  logic               reset,
    data_memory_sync_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Counter is one bit wider than the address so it never wraps.
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_reg;
    logic [ADDR_W:0]   clr_cnt_reg;
    logic [DATA_W-1:0] read_data_reg;
    logic              read_valid_reg;
    logic              busy_reg;

    logic              ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign ready = (state_reg == ST_READY);

    // Single write port shared by the clear sequencer and the pipeline.
    // A reset edge never writes the array.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.ALUResult;
        wr_data = bus.WriteData;
        if (!reset) begin
            if (state_reg == ST_CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt_reg[ADDR_W-1:0];
                wr_data = CLEAR_VAL;
            end else if (bus.MemWrite) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port. Read and write share one address, so a
    // simultaneous read+write is always a same-address access; the
    // non-blocking array update makes the plain array read "old data".
    always_ff @(posedge CLK) begin
        if (reset) begin
            read_data_reg  <= '0;
            read_valid_reg <= 1'b0;
        end else if (ready && bus.MemRead) begin
            read_valid_reg <= 1'b1;
            if (RDW_MODE == 1 && bus.MemWrite) begin
                read_data_reg <= bus.WriteData;
            end else begin
                read_data_reg <= mem[bus.ALUResult];
            end
        end else begin
            read_valid_reg <= 1'b0;
        end
    end

    // Clear sequencer: one word per edge, leaves CLEAR on the edge that
    // writes the last word.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
            busy_reg    <= 1'b1;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + CNT_ONE;
                    if (clr_cnt_reg == LAST_WORD) begin
                        state_reg <= ST_READY;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_READY;
                end
            endcase
        end
    end

    assign bus.ReadData  = read_data_reg;
    assign bus.ReadValid = read_valid_reg;
    assign bus.Busy      = busy_reg;

endmodule

// File: tb/tb_data_memory_sync.sv
// ----------------------------------------------------------------------------
// tb_data_memory_sync
// Two instances (read-first and write-first) driven with identical stimulus.
// A behavioural model (word array + clear countdown) predicts every output
// after each edge; directed table vectors add spec-derived constants.
// ----------------------------------------------------------------------------
module tb_data_memory_sync;
    localparam int             DW    = 8;
    localparam int             AW    = 4;
    localparam int             DEPTH = 16;
    localparam logic [DW-1:0]  CLR   = 8'hA5;

    logic CLK;
    logic reset;

    int checks = 0;
    int errors = 0;

    data_memory_sync_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    data_memory_sync_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    data_memory_sync #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .CLEAR_VAL(CLR)) dut0 (
        .CLK   (CLK),
        .reset (reset),
        .bus   (if0)
    );

    data_memory_sync #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .CLEAR_VAL(CLR)) dut1 (
        .CLK   (CLK),
        .reset (reset),
        .bus   (if1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clear_left;
    logic [DW-1:0] m_rd [2];
    logic          m_rv;
    logic          m_busy;

    task automatic model_edge(input logic rst, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (rst) begin
            m_clear_left = DEPTH;
            m_rd[0] = '0;
            m_rd[1] = '0;
            m_rv = 1'b0;
            m_busy = 1'b1;
        end else if (m_clear_left > 0) begin
            m_mem[DEPTH - m_clear_left] = CLR;
            m_clear_left = m_clear_left - 1;
            m_rv = 1'b0;
            m_busy = (m_clear_left > 0);
        end else begin
            if (rd) begin
                m_rd[0] = m_mem[a];
                m_rd[1] = wr ? wd : m_mem[a];
            end
            m_rv = rd;
            if (wr) m_mem[a] = wd;
        end
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One transaction: drive, clock, update model, compare both instances.
    task automatic cycle(input logic rst, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        reset = rst;
        if0.MemRead = rd; if0.MemWrite = wr; if0.ALUResult = a; if0.WriteData = wd;
        if1.MemRead = rd; if1.MemWrite = wr; if1.ALUResult = a; if1.WriteData = wd;
        @(posedge CLK);
        model_edge(rst, rd, wr, a, wd);
        #1;
        check("rdata_mode0", if0.ReadData, m_rd[0]);
        check("rdata_mode1", if1.ReadData, m_rd[1]);
        check("rvalid_mode0", {7'b0, if0.ReadValid}, {7'b0, m_rv});
        check("rvalid_mode1", {7'b0, if1.ReadValid}, {7'b0, m_rv});
        check("busy_mode0", {7'b0, if0.Busy}, {7'b0, m_busy});
        check("busy_mode1", {7'b0, if1.Busy}, {7'b0, m_busy});
        $display("txn rst=%b rd=%b wr=%b a=%h wd=%h -> rd0=%h rd1=%h rv=%b busy=%b",
                 rst, rd, wr, a, wd, if0.ReadData, if1.ReadData, if0.ReadValid, if0.Busy);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd0;
        logic [DW-1:0] exp_rd1;
        logic          exp_rv;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 4'h7, 8'h3C, 8'hA5, 8'hA5, 1'b0}; // write 7
        vecs[1]  = '{1'b1, 1'b0, 4'h7, 8'h00, 8'h3C, 8'h3C, 1'b1}; // read 7
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h3C, 8'h3C, 1'b0}; // hold
        vecs[3]  = '{1'b0, 1'b1, 4'h2, 8'h11, 8'h3C, 8'h3C, 1'b0}; // mem[2]=11
        vecs[4]  = '{1'b1, 1'b1, 4'h2, 8'h99, 8'h11, 8'h99, 1'b1}; // RDW
        vecs[5]  = '{1'b1, 1'b0, 4'h2, 8'h00, 8'h99, 8'h99, 1'b1}; // reread
        vecs[6]  = '{1'b0, 1'b1, 4'h0, 8'h10, 8'h99, 8'h99, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'h1, 8'h20, 8'h99, 8'h99, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'h2, 8'h30, 8'h99, 8'h99, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'h3, 8'h40, 8'h99, 8'h99, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'h0, 8'h00, 8'h10, 8'h10, 1'b1}; // pipelined
        vecs[11] = '{1'b1, 1'b0, 4'h1, 8'h00, 8'h20, 8'h20, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 4'h2, 8'h00, 8'h30, 8'h30, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 4'h3, 8'h00, 8'h40, 8'h40, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h40, 8'h40, 1'b0}; // drop read

        reset = 1'b1;
        if0.MemRead = 1'b0; if0.MemWrite = 1'b0; if0.ALUResult = '0; if0.WriteData = '0;
        if1.MemRead = 1'b0; if1.MemWrite = 1'b0; if1.ALUResult = '0; if1.WriteData = '0;

        // Reset held for 3 edges.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
            check("reset_rdata", if0.ReadData, 8'h00);
            check("reset_busy", {7'b0, if0.Busy}, 8'h01);
        end

        // Clear with requests hammered every cycle: Busy for exactly 16 edges.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 4'h5, 8'hFF);
            check("clear_busy", {7'b0, if0.Busy}, (i < DEPTH) ? 8'h01 : 8'h00);
            check("clear_rvalid", {7'b0, if0.ReadValid}, 8'h00);
        end

        // Every word reads back the clear value, including the one targeted during clear.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, AW'(i), 8'h00);
            check("clear_val0", if0.ReadData, CLR);
            check("clear_val1", if1.ReadData, CLR);
            check("clear_rv", {7'b0, if0.ReadValid}, 8'h01);
        end

        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check("vec_rd0", if0.ReadData, vecs[i].exp_rd0);
            check("vec_rd1", if1.ReadData, vecs[i].exp_rd1);
            check("vec_rv0", {7'b0, if0.ReadValid}, {7'b0, vecs[i].exp_rv});
            check("vec_rv1", {7'b0, if1.ReadValid}, {7'b0, vecs[i].exp_rv});
        end

        // Reset, run 8 clear edges, reset again mid-clear.
        cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        check("midrst_rdata_cleared", if0.ReadData, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
            check("midclear_busy", {7'b0, if0.Busy}, 8'h01);
        end
        cycle(1'b1, 1'b1, 1'b1, 4'h3, 8'h77);
        check("midrst_rdata", if1.ReadData, 8'h00);
        check("midrst_busy", {7'b0, if1.Busy}, 8'h01);
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
            check("restart_busy", {7'b0, if1.Busy}, (i < DEPTH) ? 8'h01 : 8'h00);
        end

        // Randomised traffic against the model, with rare resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
